// File: rtl/aq_gemac_tx_arbiter_pkg.sv
// Shared types and constants for the GEMAC TX frame-buffer arbiter.
//   NREQ      : number of frame sources sharing the MAC TX buffer
//   IDX_W     : width of a source index
//   DATA_W    : TX data word width
//   SPACE_W   : width of the MAC buffer free-space count
//   arb_state_e : arbiter FSM states
//   tx_word_t : one word presented to the MAC TX buffer
package aq_gemac_tx_arbiter_pkg;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SPACE_W = 10;

  typedef enum logic [1:0] {
    A_IDLE    = 2'd0,
    A_GRANT   = 2'd1,
    A_BUSY    = 2'd2,
    A_RELEASE = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic              we;
    logic              sof;
    logic              eof;
    logic [DATA_W-1:0] data;
  } tx_word_t;

endpackage

// File: rtl/aq_gemac_rr_pick.sv
// Combinational 4-way round-robin picker.
//   req_i   : pending requests
//   last_i  : index of the most recently served source
//   valid_o : at least one request pending
//   gnt_o   : one-hot pick (first set bit scanning last+1, last+2, ... with wrap)
//   idx_o   : binary index of the pick
module aq_gemac_rr_pick
  import aq_gemac_tx_arbiter_pkg::*;
(
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic             valid_o,
  output logic [NREQ-1:0]  gnt_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [IDX_W-1:0] cand;

  // Index arithmetic wraps naturally at IDX_W bits (3 -> 0).
  always_comb begin
    valid_o = 1'b0;
    gnt_o   = '0;
    idx_o   = '0;
    cand    = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = last_i + IDX_W'(k);
      if (!valid_o && req_i[cand]) begin
        valid_o     = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/aq_gemac_tx_arbiter.sv
// GEMAC TX frame-buffer arbiter: round-robin, whole-frame grants among 4 sources.
// Owns all drive of the MAC TX buffer write port; the data path is a zero-latency
// mux selected by the registered one-hot grant.
//
// Optional feature: define GEMAC_TX_ARB_TIMEOUT_EN to force-release a grant that
// has been idle for TIMEOUT_CYC cycles (a stalled frame is closed with a forced
// TX_END word of zero data).
//
// Ports
//   clk, rst_n    : clock, async active-low reset
//   req_i         : per-source frame pending (level)
//   gnt_o         : one-hot grant, registered
//   req_ready_o   : tx_ready_i & gnt_o (combinational)
//   req_we_i/req_start_i/req_end_i/req_data_i : per-source word interface
//   req_space_o   : tx_space_i broadcast (combinational)
//   proto_err_o   : pulse, write seen from an ungranted source (word dropped)
//   timeout_o     : pulse on forced release (always 0 without the feature)
//   tx_we_o/tx_start_o/tx_end_o/tx_data_o : MAC buffer write port (combinational)
//   tx_ready_i    : MAC buffer can accept a new frame
//   tx_space_i    : free words in MAC buffer
module aq_gemac_tx_arbiter
  import aq_gemac_tx_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned CNT_W       = 11
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_i,
  output logic [NREQ-1:0]        gnt_o,
  output logic [NREQ-1:0]        req_ready_o,
  input  logic [NREQ-1:0]        req_we_i,
  input  logic [NREQ-1:0]        req_start_i,
  input  logic [NREQ-1:0]        req_end_i,
  input  logic [NREQ*DATA_W-1:0] req_data_i,
  output logic [SPACE_W-1:0]     req_space_o,
  output logic                   proto_err_o,
  output logic                   timeout_o,
  output logic                   tx_we_o,
  output logic                   tx_start_o,
  output logic                   tx_end_o,
  output logic [DATA_W-1:0]      tx_data_o,
  input  logic                   tx_ready_i,
  input  logic [SPACE_W-1:0]     tx_space_i
);

  arb_state_e       state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [IDX_W-1:0] gidx_q, gidx_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic             proto_err_q, proto_err_d;
  logic             timeout_q, timeout_d;

  logic             pick_valid;
  logic [NREQ-1:0]  pick_gnt;
  logic [IDX_W-1:0] pick_idx;

  tx_word_t         src_word;
  tx_word_t         tx_word;
  logic             force_eof;
  logic             tmo_hit;

  aq_gemac_rr_pick u_rr_pick (
    .req_i   (req_i),
    .last_i  (last_q),
    .valid_o (pick_valid),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx)
  );

  // Source mux: only the granted source's word can reach the MAC.
  always_comb begin
    src_word = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) begin
        src_word.we   = src_word.we   | req_we_i[i];
        src_word.sof  = src_word.sof  | req_start_i[i];
        src_word.eof  = src_word.eof  | req_end_i[i];
        src_word.data = src_word.data | req_data_i[DATA_W*i +: DATA_W];
      end
    end
  end

  // A forced close replaces the source word entirely.
  always_comb begin
    tx_word = src_word;
    if (force_eof) begin
      tx_word.we   = 1'b1;
      tx_word.sof  = 1'b0;
      tx_word.eof  = 1'b1;
      tx_word.data = '0;
    end
  end

`ifdef GEMAC_TX_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Idle-cycle counter: cleared on activity or any state change.
  always_comb begin
    cnt_d = '0;
    if (!src_word.we && (state_d == state_q) &&
        ((state_q == A_GRANT) || (state_q == A_BUSY))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tmo_hit = ((state_q == A_GRANT) || (state_q == A_BUSY)) && !src_word.we &&
                   (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
  logic unused_cfg;
  assign unused_cfg = ^{TIMEOUT_CYC, CNT_W};
  assign tmo_hit    = 1'b0;
`endif

  // Next-state and grant control.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gidx_d    = gidx_q;
    last_d    = last_q;
    timeout_d = 1'b0;
    force_eof = 1'b0;
    unique case (state_q)
      A_IDLE: begin
        if (tx_ready_i && pick_valid) begin
          gnt_d   = pick_gnt;
          gidx_d  = pick_idx;
          state_d = A_GRANT;
        end
      end
      A_GRANT: begin
        // Any granted write opens the frame, START or not.
        if (src_word.we) begin
          state_d = src_word.eof ? A_RELEASE : A_BUSY;
        end else if (!(|(req_i & gnt_q))) begin
          gnt_d   = '0;
          last_d  = gidx_q;
          state_d = A_IDLE;
        end else if (tmo_hit) begin
          gnt_d     = '0;
          last_d    = gidx_q;
          timeout_d = 1'b1;
          state_d   = A_RELEASE;
        end
      end
      A_BUSY: begin
        if (src_word.we && src_word.eof) begin
          state_d = A_RELEASE;
        end else if (tmo_hit) begin
          force_eof = 1'b1;
          gnt_d     = '0;
          last_d    = gidx_q;
          timeout_d = 1'b1;
          state_d   = A_RELEASE;
        end
      end
      A_RELEASE: begin
        gnt_d   = '0;
        last_d  = gidx_q;
        state_d = A_IDLE;
      end
      default: state_d = A_IDLE;
    endcase
  end

  assign proto_err_d = |(req_we_i & ~gnt_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= A_IDLE;
      gnt_q       <= '0;
      gidx_q      <= '0;
      last_q      <= IDX_W'(NREQ - 1);
      proto_err_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gidx_q      <= gidx_d;
      last_q      <= last_d;
      proto_err_q <= proto_err_d;
      timeout_q   <= timeout_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign req_ready_o = gnt_q & {NREQ{tx_ready_i}};
  assign req_space_o = tx_space_i;
  assign proto_err_o = proto_err_q;
  assign timeout_o   = timeout_q;
  assign tx_we_o     = tx_word.we;
  assign tx_start_o  = tx_word.sof;
  assign tx_end_o    = tx_word.eof;
  assign tx_data_o   = tx_word.data;

endmodule

// File: tb/tb_aq_gemac_tx_arbiter.sv
// Bench for aq_gemac_tx_arbiter: reset checks, a per-cycle vector table, and
// scoreboarded frame sequences (round-robin order, ungranted writes, stalls/reset).
module tb_aq_gemac_tx_arbiter;
  import aq_gemac_tx_arbiter_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NREQ-1:0]        req_i, gnt_o, req_ready_o;
  logic [NREQ-1:0]        req_we_i, req_start_i, req_end_i;
  logic [NREQ*DATA_W-1:0] req_data_i;
  logic [SPACE_W-1:0]     req_space_o, tx_space_i;
  logic                   proto_err_o, timeout_o;
  logic                   tx_we_o, tx_start_o, tx_end_o, tx_ready_i;
  logic [DATA_W-1:0]      tx_data_o;

  always #5 clk = ~clk;

  aq_gemac_tx_arbiter #(.TIMEOUT_CYC(16), .CNT_W(11)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_i(req_i), .gnt_o(gnt_o), .req_ready_o(req_ready_o),
    .req_we_i(req_we_i), .req_start_i(req_start_i), .req_end_i(req_end_i),
    .req_data_i(req_data_i), .req_space_o(req_space_o),
    .proto_err_o(proto_err_o), .timeout_o(timeout_o),
    .tx_we_o(tx_we_o), .tx_start_o(tx_start_o), .tx_end_o(tx_end_o),
    .tx_data_o(tx_data_o), .tx_ready_i(tx_ready_i), .tx_space_i(tx_space_i)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic        st;
    logic        en;
    logic [31:0] d;
  } word_t;

  word_t exp_q[$];
  int    exp_gnt_q[$];

  typedef struct {
    logic [3:0]  req;
    logic        rdy;
    logic [3:0]  we, st, en;
    logic [31:0] dat;
    logic        x_we, x_st, x_en;
    logic [31:0] x_data;
    logic [3:0]  x_rdy;
    logic [3:0]  x_gnt;
    logic        x_perr;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(logic [3:0] req, logic rdy, logic [3:0] we, logic [3:0] st,
                              logic [3:0] en, logic [31:0] dat, logic x_we, logic x_st,
                              logic x_en, logic [31:0] x_data, logic [3:0] x_rdy,
                              logic [3:0] x_gnt, logic x_perr);
    vec_t v;
    v.req = req; v.rdy = rdy; v.we = we; v.st = st; v.en = en; v.dat = dat;
    v.x_we = x_we; v.x_st = x_st; v.x_en = x_en; v.x_data = x_data;
    v.x_rdy = x_rdy; v.x_gnt = x_gnt; v.x_perr = x_perr;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Lane i carries dat + i so the selected source is visible in tx_data.
  task automatic set_lanes(logic [31:0] dat);
    for (int i = 0; i < NREQ; i++) req_data_i[32*i +: 32] = dat + 32'(i);
  endtask

  task automatic clr_words();
    req_we_i = '0; req_start_i = '0; req_end_i = '0;
  endtask

  task automatic mon();
    word_t e;
    if (tx_we_o) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_tx_word: got data %0h, required no write", tx_data_o);
      end else begin
        e = exp_q.pop_front();
        chk("tx_word", 64'({tx_start_o, tx_end_o, tx_data_o}), 64'({e.st, e.en, e.d}));
      end
    end
  endtask

  // Inputs are set by the caller at posedge+1; outputs checked mid-cycle.
  task automatic step();
    #2;
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_word(int s, logic st, logic en);
    word_t e;
    req_we_i[s]           = 1'b1;
    req_start_i[s]        = st;
    req_end_i[s]          = en;
    req_data_i[32*s +: 32] = $urandom;
    e.st = st; e.en = en; e.d = req_data_i[32*s +: 32];
    exp_q.push_back(e);
  endtask

  task automatic wait_gnt(output int idx, output bit ok);
    ok  = 1'b0;
    idx = -1;
    for (int c = 0; c < 50; c++) begin
      if (gnt_o != '0) begin
        ok = 1'b1;
        for (int i = 0; i < NREQ; i++) if (gnt_o[i]) idx = i;
        break;
      end
      step();
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_gnt: got no grant within 50 cycles, required a grant");
    end
  endtask

  task automatic send(int s, int n);
    for (int w = 0; w < n; w++) begin
      clr_words();
      drive_word(s, w == 0, w == n - 1);
      step();
    end
    clr_words();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  idx;
    bit  ok;
    int  z;
    bit  flag;

    // Row: req rdy we st en dat | tx_we st en data ready | gnt_after perr_after
    tbl[0]  = mk(4'b0001,1,4'b0000,4'b0000,4'b0000,32'h0,    0,0,0,32'h0,    4'b0000,4'b0001,0);
    tbl[1]  = mk(4'b0001,1,4'b0001,4'b0001,4'b0000,32'h1000, 1,1,0,32'h1000, 4'b0001,4'b0001,0);
    tbl[2]  = mk(4'b0001,1,4'b0001,4'b0000,4'b0000,32'h2000, 1,0,0,32'h2000, 4'b0001,4'b0001,0);
    tbl[3]  = mk(4'b0001,1,4'b0101,4'b0100,4'b0000,32'h3000, 1,0,0,32'h3000, 4'b0001,4'b0001,1);
    tbl[4]  = mk(4'b0001,1,4'b0001,4'b0000,4'b0001,32'h4000, 1,0,1,32'h4000, 4'b0001,4'b0001,0);
    tbl[5]  = mk(4'b0000,1,4'b0000,4'b0000,4'b0000,32'h5000, 0,0,0,32'h5000, 4'b0001,4'b0000,0);
    tbl[6]  = mk(4'b0010,0,4'b0000,4'b0000,4'b0000,32'h0,    0,0,0,32'h0,    4'b0000,4'b0000,0);
    tbl[7]  = mk(4'b0010,0,4'b0000,4'b0000,4'b0000,32'h0,    0,0,0,32'h0,    4'b0000,4'b0000,0);
    tbl[8]  = mk(4'b0010,1,4'b0000,4'b0000,4'b0000,32'h0,    0,0,0,32'h0,    4'b0000,4'b0010,0);
    tbl[9]  = mk(4'b0010,1,4'b0010,4'b0010,4'b0010,32'h9000, 1,1,1,32'h9001, 4'b0010,4'b0010,0);
    tbl[10] = mk(4'b0000,1,4'b0000,4'b0000,4'b0000,32'hA000, 0,0,0,32'hA001, 4'b0010,4'b0000,0);
    tbl[11] = mk(4'b1001,1,4'b0000,4'b0000,4'b0000,32'h0,    0,0,0,32'h0,    4'b0000,4'b1000,0);
    tbl[12] = mk(4'b0001,1,4'b0000,4'b0000,4'b0000,32'hC000, 0,0,0,32'hC003, 4'b1000,4'b0000,0);
    tbl[13] = mk(4'b0001,1,4'b0000,4'b0000,4'b0000,32'h0,    0,0,0,32'h0,    4'b0000,4'b0001,0);
    tbl[14] = mk(4'b0000,1,4'b0000,4'b0000,4'b0000,32'hE000, 0,0,0,32'hE000, 4'b0001,4'b0000,0);
    tbl[15] = mk(4'b1000,1,4'b0000,4'b0000,4'b0000,32'h0,    0,0,0,32'h0,    4'b0000,4'b1000,0);
    tbl[16] = mk(4'b1000,1,4'b1000,4'b1000,4'b1000,32'h6000, 1,1,1,32'h6003, 4'b1000,4'b1000,0);
    tbl[17] = mk(4'b1001,1,4'b0000,4'b0000,4'b0000,32'h0,    0,0,0,32'h3,    4'b1000,4'b0000,0);
    tbl[18] = mk(4'b1001,1,4'b0000,4'b0000,4'b0000,32'h0,    0,0,0,32'h0,    4'b0000,4'b0001,0);
    tbl[19] = mk(4'b0000,1,4'b0000,4'b0000,4'b0000,32'h0,    0,0,0,32'h0,    4'b0001,4'b0000,0);

    // Reset state, with every source writing into the arbiter.
    rst_n = 1'b0;
    req_i = '0; tx_ready_i = 1'b1; tx_space_i = 10'h2A5;
    req_we_i = '1; req_start_i = '1; req_end_i = '1;
    set_lanes(32'h5555_0000);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_gnt", 64'(gnt_o), 64'(0));
    chk("reset_proto_err", 64'(proto_err_o), 64'(0));
    chk("reset_timeout", 64'(timeout_o), 64'(0));
    chk("reset_tx", 64'({tx_we_o, tx_start_o, tx_end_o, tx_data_o}), 64'(0));
    chk("space_passthru", 64'(req_space_o), 64'(10'h2A5));
    clr_words();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Per-cycle vector table.
    for (int r = 0; r < 20; r++) begin
      req_i = tbl[r].req; tx_ready_i = tbl[r].rdy;
      req_we_i = tbl[r].we; req_start_i = tbl[r].st; req_end_i = tbl[r].en;
      set_lanes(tbl[r].dat);
      #2;
      chk($sformatf("row%0d_tx", r),
          64'({tx_we_o, tx_start_o, tx_end_o, tx_data_o, req_ready_o}),
          64'({tbl[r].x_we, tbl[r].x_st, tbl[r].x_en, tbl[r].x_data, tbl[r].x_rdy}));
      @(posedge clk);
      #1;
      chk($sformatf("row%0d_gnt", r), 64'(gnt_o), 64'(tbl[r].x_gnt));
      chk($sformatf("row%0d_perr", r), 64'(proto_err_o), 64'(tbl[r].x_perr));
    end
    clr_words(); req_i = '0;

    // Round-robin with all sources requesting: order 0,1,2,3,0 and one dead cycle.
    do_reset();
    chk("rr_reset_gnt", 64'(gnt_o), 64'(0));
    exp_gnt_q = '{0, 1, 2, 3, 0};
    req_i = 4'b1111; tx_ready_i = 1'b1;
    for (int f = 0; f < 5; f++) begin
      wait_gnt(idx, ok);
      chk($sformatf("rr_order%0d", f), 64'(idx), 64'(exp_gnt_q.pop_front()));
      if (!ok) break;
      send(idx, 3);
      if (f == 4) req_i = '0;
      if (f < 4) begin
        z = 0;
        for (int c = 0; c < 10; c++) begin
          step();
          if (gnt_o == '0) z++;
          else if (z > 0) break;
        end
        chk($sformatf("rr_gap%0d", f), 64'(z), 64'(1));
      end
    end
    repeat (3) step();

    // Source 2 writes while source 1 owns the buffer.
    req_i = 4'b0010;
    wait_gnt(idx, ok);
    chk("s1_granted", 64'(idx), 64'(1));
    clr_words(); drive_word(1, 1'b1, 1'b0); step();
    clr_words(); drive_word(1, 1'b0, 1'b0);
    req_we_i[2] = 1'b1; req_start_i[2] = 1'b1; req_end_i[2] = 1'b1;
    req_data_i[64 +: 32] = 32'hBAD0_BAD0;
    step();
    chk("proto_err_pulse", 64'(proto_err_o), 64'(1));
    clr_words(); drive_word(1, 1'b0, 1'b1); step();
    chk("proto_err_clear", 64'(proto_err_o), 64'(0));
    clr_words(); req_i = '0;
    repeat (3) step();
    chk("s1_released", 64'(gnt_o), 64'(0));

`ifdef GEMAC_TX_ARB_TIMEOUT_EN
    // Stalled source 0: forced END word at the 16th idle cycle.
    do_reset();
    req_i = 4'b0001;
    wait_gnt(idx, ok);
    clr_words(); drive_word(0, 1'b1, 1'b0); step();
    clr_words();
    flag = 1'b0;
    for (int k = 1; k < 16; k++) begin
      req_data_i[0 +: 32] = 32'hDEAD_0000 + 32'(k);
      #2;
      if (tx_we_o) flag = 1'b1;
      @(posedge clk);
      #1;
    end
    chk("tmo_no_early_force", 64'(flag), 64'(0));
    req_data_i[0 +: 32] = 32'hDEAD_BEEF;
    #2;
    chk("tmo_forced_word", 64'({tx_we_o, tx_start_o, tx_end_o, tx_data_o}),
        64'({1'b1, 1'b0, 1'b1, 32'h0}));
    @(posedge clk);
    #1;
    chk("tmo_pulse", 64'({timeout_o, gnt_o}), 64'({1'b1, 4'b0000}));
    step();
    chk("tmo_pulse_end", 64'(timeout_o), 64'(0));
    req_i = '0;
    repeat (2) step();

    // Reset mid-frame drops the grant and the write path at once.
    req_i = 4'b0001;
    wait_gnt(idx, ok);
    clr_words(); drive_word(0, 1'b1, 1'b0); step();
    clr_words();
    req_we_i[0] = 1'b1; req_data_i[0 +: 32] = 32'h1234_5678;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_frame", 64'({gnt_o, tx_we_o}), 64'({4'b0000, 1'b0}));
    clr_words(); req_i = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
`else
    // Without the timeout a stalled source keeps the buffer indefinitely.
    do_reset();
    req_i = 4'b0001;
    wait_gnt(idx, ok);
    clr_words(); drive_word(0, 1'b1, 1'b0); step();
    clr_words();
    flag = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (timeout_o) flag = 1'b1;
    end
    chk("stall_no_timeout", 64'(flag), 64'(0));
    chk("stall_gnt_held", 64'(gnt_o), 64'(4'b0001));
    drive_word(0, 1'b0, 1'b1); step();
    clr_words(); req_i = '0;
    repeat (2) step();
    chk("stall_released", 64'(gnt_o), 64'(0));
`endif

    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
